// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction ROM port, decode-side outputs, branch and LUT-write inputs.
// Optional cycle/retire counters exist only when INSTR_FETCH_CYCLE_CNT_EN is defined.
interface instr_fetch_if #(
    parameter int PC_W      = 10,
    parameter int INSTR_W   = 9,
    parameter int LUT_DEPTH = 32
);
    localparam int IDX_W = $clog2(LUT_DEPTH);

    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [PC_W-1:0]    pc;
    logic               stall;
    logic               br_take;
    logic               br_rel;
    logic [7:0]         br_off;
    logic [IDX_W-1:0]   br_idx;
    logic               lut_we;
    logic [IDX_W-1:0]   lut_addr;
    logic [PC_W-1:0]    lut_data;
    logic               done;
`ifdef INSTR_FETCH_CYCLE_CNT_EN
    logic [15:0]        cycle_cnt;
    logic [15:0]        retire_cnt;
`endif

    modport master (
        output imem_addr, instr, instr_valid, pc, done,
`ifdef INSTR_FETCH_CYCLE_CNT_EN
        output cycle_cnt, retire_cnt,
`endif
        input  imem_data, stall, br_take, br_rel, br_off, br_idx,
        input  lut_we, lut_addr, lut_data
    );

    modport slave (
        input  imem_addr, instr, instr_valid, pc, done,
`ifdef INSTR_FETCH_CYCLE_CNT_EN
        input  cycle_cnt, retire_cnt,
`endif
        output imem_data, stall, br_take, br_rel, br_off, br_idx,
        output lut_we, lut_addr, lut_data
    );
endinterface

// File: rtl/instr_fetch.sv
// X9 program counter / fetch stage: BOOT-RUN-HALTED FSM, relative and LUT branches, sticky done.
// Define INSTR_FETCH_CYCLE_CNT_EN to add saturating cycle_cnt / retire_cnt outputs.
module instr_fetch #(
    parameter int                 PC_W      = 10,
    parameter int                 INSTR_W   = 9,
    parameter logic [INSTR_W-1:0] HALT_OP   = 9'h1FF,
    parameter int                 LUT_DEPTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);
    localparam int IDX_W = $clog2(LUT_DEPTH);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] lut_q [LUT_DEPTH];
    logic [PC_W-1:0] off_ext;
    logic            is_halt;

    assign off_ext = {{(PC_W-8){bus.br_off[7]}}, bus.br_off};
    assign is_halt = (bus.imem_data == HALT_OP);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            BOOT:   state_d = RUN;
            RUN: begin
                if (!bus.stall) begin
                    if (is_halt) begin
                        state_d = HALTED;
                    end else if (bus.br_take && bus.br_rel) begin
                        pc_d = pc_q + off_ext;
                    end else if (bus.br_take) begin
                        pc_d = lut_q[bus.br_idx];
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // NOTE: the LUT must read as zero right after reset, so it is built from resettable flops, not RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
        end else if (bus.lut_we) begin
            lut_q[bus.lut_addr] <= bus.lut_data;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instr       = bus.imem_data;
    assign bus.instr_valid = (state_q == RUN);
    assign bus.done        = (state_q == HALTED);

`ifdef INSTR_FETCH_CYCLE_CNT_EN
    logic [15:0] cycle_q, retire_q;
    logic        retire;

    // The HALT word itself ends the program and is not counted as retired.
    assign retire = (state_q == RUN) && !bus.stall && !is_halt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q  <= '0;
            retire_q <= '0;
        end else begin
            if (state_q != HALTED && cycle_q != 16'hFFFF) cycle_q <= cycle_q + 16'd1;
            if (retire && retire_q != 16'hFFFF)           retire_q <= retire_q + 16'd1;
        end
    end

    assign bus.cycle_cnt  = cycle_q;
    assign bus.retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed boot/branch/priority/reset scenarios, then a
// randomized run compared every cycle against a behavioural model of the fetch rules.
module tb_instr_fetch;
    localparam int          PC_W      = 10;
    localparam int          INSTR_W   = 9;
    localparam int          LUT_DEPTH = 32;
    localparam int          PC_MOD    = 1 << PC_W;
    localparam logic [8:0]  HALT      = 9'h1FF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .LUT_DEPTH(LUT_DEPTH)) bus ();

    instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .HALT_OP(HALT), .LUT_DEPTH(LUT_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [INSTR_W-1:0] rom [PC_MOD];
    assign bus.imem_data = rom[bus.imem_addr];

    int n_vec  = 0;
    int n_miss = 0;

    // Behavioural model state.
    bit m_boot, m_halted;
    int m_pc, m_cyc, m_ret;
    int m_lut [LUT_DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.stall    = 1'b0;
        bus.br_take  = 1'b0;
        bus.br_rel   = 1'b0;
        bus.br_off   = '0;
        bus.br_idx   = '0;
        bus.lut_we   = 1'b0;
        bus.lut_addr = '0;
        bus.lut_data = '0;
    endtask

    task automatic model_reset();
        m_boot   = 1'b1;
        m_halted = 1'b0;
        m_pc     = 0;
        m_cyc    = 0;
        m_ret    = 0;
        for (int i = 0; i < LUT_DEPTH; i++) m_lut[i] = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        int nxt;
        int off;
        nxt = m_pc;
        if (!m_halted && m_cyc < 65535) m_cyc++;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (!m_halted && !bus.stall) begin
            if (rom[m_pc] == HALT) begin
                m_halted = 1'b1;
            end else begin
                if (m_ret < 65535) m_ret++;
                if (bus.br_take && bus.br_rel) begin
                    off = int'($signed(bus.br_off));
                    nxt = (m_pc + off + PC_MOD) % PC_MOD;
                end else if (bus.br_take) begin
                    nxt = m_lut[bus.br_idx];
                end else begin
                    nxt = (m_pc + 1) % PC_MOD;
                end
            end
        end
        if (bus.lut_we) m_lut[bus.lut_addr] = int'(bus.lut_data);
        m_pc = nxt;
    endtask

    task automatic compare_outputs();
        check("pc",          32'(bus.pc),          32'(m_pc));
        check("imem_addr",   32'(bus.imem_addr),   32'(m_pc));
        check("instr",       32'(bus.instr),       32'(rom[m_pc]));
        check("instr_valid", 32'(bus.instr_valid), 32'(!m_boot && !m_halted));
        check("done",        32'(bus.done),        32'(m_halted));
`ifdef INSTR_FETCH_CYCLE_CNT_EN
        check("cycle_cnt",   32'(bus.cycle_cnt),   32'(m_cyc));
        check("retire_cnt",  32'(bus.retire_cnt),  32'(m_ret));
`endif
    endtask

    // Called at posedge+1; returns at the next posedge+1 with outputs compared.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    // Half-cycle asynchronous reset pulse, checked before any clock edge arrives.
    task automatic async_reset();
        drive_idle();
        #1 reset = 1'b0;
        model_reset();
        #1;
        check("rst_pc",    32'(bus.pc),          32'd0);
        check("rst_done",  32'(bus.done),        32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        #4 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive_idle();
        for (int i = 0; i < PC_MOD; i++) rom[i] = '0;
        model_reset();
        #22;
        check("reset_pc",    32'(bus.imem_addr),   32'd0);
        check("reset_valid", 32'(bus.instr_valid), 32'd0);
        check("reset_done",  32'(bus.done),        32'd0);
        reset = 1'b1;

        // Relative branch with wrap below zero, then increment wrap from all-ones.
        step();
        check("boot_valid", 32'(bus.instr_valid), 32'd1);
        step(); step();
        check("pc_at_2", 32'(bus.pc), 32'd2);
        bus.br_take = 1'b1; bus.br_rel = 1'b1; bus.br_off = 8'hFD;
        step(); drive_idle();
        check("rel_wrap", 32'(bus.pc), 32'h3FF);
        step();
        check("inc_wrap", 32'(bus.pc), 32'h000);

        // LUT branch; a same-cycle write to the same entry must not affect the target.
        rom[10'h120] = 9'h0A5;
        rom[10'h121] = HALT;
        bus.lut_we = 1'b1; bus.lut_addr = 5'd7; bus.lut_data = 10'h120;
        step();
        bus.lut_addr = 5'd3; bus.lut_data = 10'h120;
        step(); drive_idle();
        step(); step(); step();
        check("pc_at_5", 32'(bus.pc), 32'd5);
        bus.br_take = 1'b1; bus.br_rel = 1'b0; bus.br_idx = 5'd7;
        bus.lut_we = 1'b1; bus.lut_addr = 5'd7; bus.lut_data = 10'h050;
        step(); drive_idle();
        check("lut_old_entry", 32'(bus.pc), 32'h120);
        bus.br_take = 1'b1; bus.br_idx = 5'd7;
        step();
        check("lut_new_entry", 32'(bus.pc), 32'h050);
        bus.br_idx = 5'd3;
        step(); drive_idle();
        check("lut_back", 32'(bus.pc), 32'h120);

        // Stall outranks branch: PC and instr hold for three cycles.
        for (int i = 0; i < 3; i++) begin
            bus.stall = 1'b1; bus.br_take = 1'b1;
            bus.br_rel = 1'($urandom_range(0, 1)); bus.br_off = 8'($urandom); bus.br_idx = 5'd7;
            step();
            check("stall_pc",    32'(bus.pc),    32'h120);
            check("stall_instr", 32'(bus.instr), 32'h0A5);
        end
        drive_idle();
        step();
        check("halt_seen", 32'(bus.instr), 32'(HALT));
        // HALT outranks a taken branch.
        bus.br_take = 1'b1; bus.br_rel = 1'b1; bus.br_off = 8'h10;
        step();
        check("halt_done", 32'(bus.done), 32'd1);
        check("halt_pc",   32'(bus.pc),   32'h121);
        bus.stall = 1'b0; bus.br_rel = 1'b0;
        step(); step(); drive_idle();
        check("halted_frozen", 32'(bus.pc), 32'h121);

        // Reset/boot program with one stall at PC=1.
        rom[10'h120] = '0; rom[10'h121] = '0;
        rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h003; rom[3] = HALT;
        async_reset();
        step();  check("boot_addr0", 32'(bus.imem_addr), 32'd0);
        step();  check("run_addr1",  32'(bus.imem_addr), 32'd1);
        bus.stall = 1'b1;
        step();  check("stall_addr1", 32'(bus.imem_addr), 32'd1);
        bus.stall = 1'b0;
        step();  check("run_addr2", 32'(bus.imem_addr), 32'd2);
        step();  check("run_addr3", 32'(bus.imem_addr), 32'd3);
        step();  check("prog_done", 32'(bus.done), 32'd1);
`ifdef INSTR_FETCH_CYCLE_CNT_EN
        check("cnt_cycle_halt",  32'(bus.cycle_cnt),  32'd6);
        check("cnt_retire_halt", 32'(bus.retire_cnt), 32'd3);
`endif
        bus.lut_we = 1'b1; bus.lut_addr = 5'd9; bus.lut_data = 10'h2AA;
        step(); drive_idle();
        step();
        check("prog_pc_held", 32'(bus.pc), 32'd3);
`ifdef INSTR_FETCH_CYCLE_CNT_EN
        check("cnt_cycle_frozen",  32'(bus.cycle_cnt),  32'd6);
        check("cnt_retire_frozen", 32'(bus.retire_cnt), 32'd3);
`endif

        // Reset from HALTED clears the LUT: LUT branches afterwards land on 0.
        async_reset();
        step(); step();
        bus.br_take = 1'b1; bus.br_idx = 5'd9;
        step(); drive_idle();
        check("lut9_cleared", 32'(bus.pc), 32'd0);
        step();
        bus.br_take = 1'b1; bus.br_idx = 5'd7;
        step(); drive_idle();
        check("lut7_cleared", 32'(bus.pc), 32'd0);

        // Randomized run against the model, with occasional HALTs and async resets.
        for (int i = 0; i < PC_MOD; i++) rom[i] = 9'($urandom_range(0, 9'h1FE));
        for (int i = 0; i < 6; i++) rom[$urandom_range(0, PC_MOD - 1)] = HALT;
        async_reset();
        for (int c = 0; c < 1500; c++) begin
            if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                bus.stall    = ($urandom_range(0, 3) == 0);
                bus.br_take  = ($urandom_range(0, 3) == 0);
                bus.br_rel   = 1'($urandom_range(0, 1));
                bus.br_off   = 8'($urandom);
                bus.br_idx   = 5'($urandom);
                bus.lut_we   = ($urandom_range(0, 2) == 0);
                bus.lut_addr = 5'($urandom);
                bus.lut_data = 10'($urandom);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
